exe_stage: RTL and testbench
============================

EXE_STAGE -- requirements
Module: exe_stage

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst_n  in  1  reset, asynchronous and active-low; one clock, no other clock domains.
REQ-003 mem_allowin_in  in  1  MEM stage can accept an instruction this cycle.
REQ-004 exe_allowin_out  out  1  EXE can accept an instruction from ID this cycle.
REQ-005 id_valid_in  in  1  ID presents a valid instruction.
REQ-006 exe_valid_out  out  1  EXE holds a finished instruction for MEM.
REQ-007 id_aluop_in  in  12  one-hot op: [0]ADD [1]SUB [2]SLT [3]SLTU [4]AND [5]NOR [6]OR [7]XOR [8]SLL [9]SRL [10]SRA [11]LUI.
REQ-008 id_aludata1_in, id_aludata2_in  in  32 each  ALU operands (shift amount in data1[4:0]).
REQ-009 id_RD2_in  in  32  store data.
REQ-010 id_sel_dm_in  in  2  [0]=load, [1]=store, 00=no memory op.
REQ-011 id_sbhw_con_in  in  3  one-hot store size: [0]byte [1]half [2]word.
REQ-012 id_regnum_in  in  5; id_write_type_in  in  3; id_sel_wbdata_in  in  4; id_PC_in, id_NNPC_in  in  32 each  passthrough fields.
REQ-013 exe_alures_out  out  32  ALU result of held instruction.
REQ-014 exe_regnum_out  out  5; exe_write_type_out  out  3; exe_sel_wbdata_out  out  4; exe_PC_out, exe_NNPC_out  out  32 each  registered passthroughs.
REQ-015 exe_write_type, exe_wnum  out  3, 5  hazard info to ID: exe_write_type = 3'b000 when stage empty, else held write_type; exe_wnum = held regnum.
REQ-016 data_req  out  1; data_wr  out  1; data_wstrb  out  4; data_addr  out  32; data_wdata  out  32  data-SRAM request channel.
REQ-017 data_addr_ok  in  1  SRAM accepted the request this cycle (valid only while data_req=1).

Function
REQ-018 valid_r: when exe_allowin_out=1, valid_r <= id_valid_in; otherwise unchanged.
REQ-019 exe_allowin_out = !valid_r || (ready && mem_allowin_in).
REQ-020 exe_valid_out = valid_r && ready.
REQ-021 All input fields latch into stage registers only when exe_allowin_out && id_valid_in; registers otherwise hold.
REQ-022 ALU is combinational on the held operands; result valid the cycle after capture (1-cycle stage latency for non-memory ops).
REQ-023 ADD/SUB wrap modulo 2^32, no overflow trap; SLT signed, SLTU unsigned, result 0/1 zero-extended; shifts use data1[4:0] on data2; LUI = {data2[15:0],16'h0}; all-zero aluop yields 0.
REQ-024 Memory FSM states: IDLE, REQ, DONE.
REQ-025 Capture of an instruction with sel_dm!=00 -> REQ; capture of a non-memory instruction -> IDLE.
REQ-026 REQ: data_req=1; data_addr_ok=1 -> DONE; else stay in REQ, request fields held stable.
REQ-027 DONE: data_req=0; stays DONE until the instruction leaves (ready && mem_allowin_in), then next state per REQ-025 or IDLE if nothing captured.
REQ-028 ready = (sel_dm_r==00) || state==DONE || (state==REQ && data_addr_ok).
REQ-029 data_addr = ALU result; data_wr = sel_dm_r[1].
REQ-030 Stores: byte -> wstrb = 4'b0001 << addr[1:0], wdata = {4{RD2[7:0]}}; half -> wstrb = addr[1] ? 4'b1100 : 4'b0011, wdata = {2{RD2[15:0]}}; word -> wstrb 4'b1111, wdata = RD2.
REQ-031 Loads: wstrb = 4'b0000, wdata = 0.
REQ-032 Misaligned addresses are not checked here; the request is issued unchanged.
REQ-033 MEM stalled (mem_allowin_in=0) with instruction in DONE: no second request; all outputs held.
REQ-034 data_addr_ok and mem_allowin_in both high in the same REQ cycle: the instruction leaves that cycle and the next instruction may be captured simultaneously.

Reset
REQ-035 On rst_n=0 (async): valid_r=0, FSM=IDLE, all stage registers 0; hence exe_valid_out=0, exe_allowin_out=1, data_req=0, exe_write_type=000.
REQ-036 Reset while in REQ aborts the request immediately; no request reissued after reset release.

Verification
REQ-037 ADD: data1=32'hFFFF_FFFF, data2=1, mem_allowin=1 -> next cycle exe_alures_out=0, exe_valid_out=1, data_req=0.
REQ-038 SLT: data1=32'h8000_0000, data2=1 -> result 1; same operands with SLTU -> result 0; SRA with data1=4, data2=32'h8000_0000 -> 32'hF800_0000.
REQ-039 Store byte, address 32'h1000_0003, RD2=32'h0000_00AB, data_addr_ok delayed 3 cycles -> data_req=1 for 3 cycles with stable fields, wstrb=4'b1000, wdata=32'hABAB_ABAB, exe_allowin_out=0 until accept.
REQ-040 Load accepted while mem_allowin_in=0 for 2 cycles -> exactly one data_req pulse, exe_valid_out=1 held, no new capture until MEM allows.
REQ-041 Back-to-back ALU ops with mem_allowin=1 -> one instruction per cycle, exe_wnum/exe_write_type track each; stage empty -> exe_write_type=000.
REQ-042 Assert rst_n=0 mid-REQ -> data_req drops without waiting for a clock edge; after release exe_allowin_out=1, no stray request.

Source files
------------

// File: rtl/exe_stage_if.sv
// Purpose : bundles the EXE stage pipeline handshake, passthrough fields,
//           hazard info and data-SRAM request channel into one port.
// Ports   : master = ID/MEM/SRAM side (drives id_*, mem_allowin_in, data_addr_ok);
//           slave  = exe_stage (drives exe_*, data_* request fields).
interface exe_stage_if;
  // pipeline handshake
  logic        mem_allowin_in;
  logic        exe_allowin_out;
  logic        id_valid_in;
  logic        exe_valid_out;
  // instruction fields from ID
  logic [11:0] id_aluop_in;
  logic [31:0] id_aludata1_in;
  logic [31:0] id_aludata2_in;
  logic [31:0] id_RD2_in;
  logic [1:0]  id_sel_dm_in;
  logic [2:0]  id_sbhw_con_in;
  logic [4:0]  id_regnum_in;
  logic [2:0]  id_write_type_in;
  logic [3:0]  id_sel_wbdata_in;
  logic [31:0] id_PC_in;
  logic [31:0] id_NNPC_in;
  // registered results towards MEM
  logic [31:0] exe_alures_out;
  logic [4:0]  exe_regnum_out;
  logic [2:0]  exe_write_type_out;
  logic [3:0]  exe_sel_wbdata_out;
  logic [31:0] exe_PC_out;
  logic [31:0] exe_NNPC_out;
  // hazard info towards ID
  logic [2:0]  exe_write_type;
  logic [4:0]  exe_wnum;
  // data-SRAM request channel
  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;

  modport master (
    output mem_allowin_in, id_valid_in, id_aluop_in, id_aludata1_in, id_aludata2_in,
           id_RD2_in, id_sel_dm_in, id_sbhw_con_in, id_regnum_in, id_write_type_in,
           id_sel_wbdata_in, id_PC_in, id_NNPC_in, data_addr_ok,
    input  exe_allowin_out, exe_valid_out, exe_alures_out, exe_regnum_out,
           exe_write_type_out, exe_sel_wbdata_out, exe_PC_out, exe_NNPC_out,
           exe_write_type, exe_wnum, data_req, data_wr, data_wstrb, data_addr, data_wdata
  );

  modport slave (
    input  mem_allowin_in, id_valid_in, id_aluop_in, id_aludata1_in, id_aludata2_in,
           id_RD2_in, id_sel_dm_in, id_sbhw_con_in, id_regnum_in, id_write_type_in,
           id_sel_wbdata_in, id_PC_in, id_NNPC_in, data_addr_ok,
    output exe_allowin_out, exe_valid_out, exe_alures_out, exe_regnum_out,
           exe_write_type_out, exe_sel_wbdata_out, exe_PC_out, exe_NNPC_out,
           exe_write_type, exe_wnum, data_req, data_wr, data_wstrb, data_addr, data_wdata
  );
endinterface

// File: rtl/exe_stage.sv
// Purpose : pipeline EXE stage - one-hot ALU plus data-SRAM request issue for loads/stores.
// Latency : 1 cycle for ALU ops; memory ops wait in the stage until the SRAM accepts the request.
// Backpr. : holds the instruction (allowin low) until ready and MEM allows; no re-request while stalled.
// Ports   : clk, rst_n (async active-low), bus (exe_stage_if.slave: ID in, MEM out, SRAM request).
module exe_stage (
  input  logic           clk,
  input  logic           rst_n,
  exe_stage_if.slave     bus
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} mem_state_e;

  mem_state_e  state, state_nxt;
  logic        valid_r;
  logic        ready;
  logic        allowin;
  logic        capture;
  logic        leave;

  logic [11:0] aluop_r;
  logic [31:0] data1_r;
  logic [31:0] data2_r;
  logic [31:0] rd2_r;
  logic [1:0]  sel_dm_r;
  logic [2:0]  sbhw_r;
  logic [4:0]  regnum_r;
  logic [2:0]  write_type_r;
  logic [3:0]  sel_wbdata_r;
  logic [31:0] pc_r;
  logic [31:0] nnpc_r;

  logic [31:0] alu_res;
  logic [4:0]  shamt;
  logic [3:0]  wstrb;
  logic [31:0] wdata;

  // ready also covers the accept cycle so a request can retire the same cycle it is taken
  assign ready   = (sel_dm_r == 2'b00) || (state == DONE) ||
                   ((state == REQ) && bus.data_addr_ok);
  assign allowin = !valid_r || (ready && bus.mem_allowin_in);
  assign capture = allowin && bus.id_valid_in;
  assign leave   = valid_r && ready && bus.mem_allowin_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= 1'b0;
    end else if (allowin) begin
      valid_r <= bus.id_valid_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aluop_r      <= '0;
      data1_r      <= '0;
      data2_r      <= '0;
      rd2_r        <= '0;
      sel_dm_r     <= '0;
      sbhw_r       <= '0;
      regnum_r     <= '0;
      write_type_r <= '0;
      sel_wbdata_r <= '0;
      pc_r         <= '0;
      nnpc_r       <= '0;
    end else if (capture) begin
      aluop_r      <= bus.id_aluop_in;
      data1_r      <= bus.id_aludata1_in;
      data2_r      <= bus.id_aludata2_in;
      rd2_r        <= bus.id_RD2_in;
      sel_dm_r     <= bus.id_sel_dm_in;
      sbhw_r       <= bus.id_sbhw_con_in;
      regnum_r     <= bus.id_regnum_in;
      write_type_r <= bus.id_write_type_in;
      sel_wbdata_r <= bus.id_sel_wbdata_in;
      pc_r         <= bus.id_PC_in;
      nnpc_r       <= bus.id_NNPC_in;
    end
  end

  // Memory request FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (capture) begin
      state_nxt = (bus.id_sel_dm_in != 2'b00) ? REQ : IDLE;
    end else if (leave) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        REQ:     state_nxt = bus.data_addr_ok ? DONE : REQ;
        DONE:    state_nxt = DONE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // ALU on held operands; aluop is one-hot, all-zero falls to the default
  assign shamt = data1_r[4:0];

  always_comb begin
    alu_res = '0;
    case (1'b1)
      aluop_r[0]:  alu_res = data1_r + data2_r;
      aluop_r[1]:  alu_res = data1_r - data2_r;
      aluop_r[2]:  alu_res = {31'd0, $signed(data1_r) < $signed(data2_r)};
      aluop_r[3]:  alu_res = {31'd0, data1_r < data2_r};
      aluop_r[4]:  alu_res = data1_r & data2_r;
      aluop_r[5]:  alu_res = ~(data1_r | data2_r);
      aluop_r[6]:  alu_res = data1_r | data2_r;
      aluop_r[7]:  alu_res = data1_r ^ data2_r;
      aluop_r[8]:  alu_res = data2_r << shamt;
      aluop_r[9]:  alu_res = data2_r >> shamt;
      aluop_r[10]: alu_res = $signed(data2_r) >>> shamt;
      aluop_r[11]: alu_res = {data2_r[15:0], 16'h0000};
      default:     alu_res = '0;
    endcase
  end

  // Store lane steering; loads and non-memory ops drive zero strobes/data
  always_comb begin
    wstrb = 4'b0000;
    wdata = '0;
    if (sel_dm_r[1]) begin
      if (sbhw_r[0]) begin
        wstrb = 4'b0001 << alu_res[1:0];
        wdata = {4{rd2_r[7:0]}};
      end else if (sbhw_r[1]) begin
        wstrb = alu_res[1] ? 4'b1100 : 4'b0011;
        wdata = {2{rd2_r[15:0]}};
      end else if (sbhw_r[2]) begin
        wstrb = 4'b1111;
        wdata = rd2_r;
      end
    end
  end

  assign bus.exe_allowin_out    = allowin;
  assign bus.exe_valid_out      = valid_r && ready;
  assign bus.exe_alures_out     = alu_res;
  assign bus.exe_regnum_out     = regnum_r;
  assign bus.exe_write_type_out = write_type_r;
  assign bus.exe_sel_wbdata_out = sel_wbdata_r;
  assign bus.exe_PC_out         = pc_r;
  assign bus.exe_NNPC_out       = nnpc_r;
  assign bus.exe_write_type     = valid_r ? write_type_r : 3'b000;
  assign bus.exe_wnum           = regnum_r;

  // data_req comes straight from the state register so async reset drops it immediately
  assign bus.data_req   = (state == REQ);
  assign bus.data_wr    = sel_dm_r[1];
  assign bus.data_addr  = alu_res;
  assign bus.data_wstrb = wstrb;
  assign bus.data_wdata = wdata;

endmodule

// File: tb/tb_exe_stage.sv
// Purpose : directed self-checking bench for exe_stage (ALU ops, stores, loads, stalls, reset).
// Latency : inputs driven on falling edge, outputs sampled 1ns later; DUT captures on rising edge.
// Backpr. : mem_allowin_in / data_addr_ok driven directly by the stimulus sequence.
module tb_exe_stage;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  exe_stage_if bus ();

  exe_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete (got timeout, expected finish)");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic issue(input logic [11:0] op, input logic [31:0] d1, input logic [31:0] d2,
                       input logic [1:0] dm, input logic [2:0] sz, input logic [31:0] rd2,
                       input logic [4:0] rn, input logic [2:0] wt);
    bus.id_valid_in      = 1'b1;
    bus.id_aluop_in      = op;
    bus.id_aludata1_in   = d1;
    bus.id_aludata2_in   = d2;
    bus.id_sel_dm_in     = dm;
    bus.id_sbhw_con_in   = sz;
    bus.id_RD2_in        = rd2;
    bus.id_regnum_in     = rn;
    bus.id_write_type_in = wt;
    bus.id_sel_wbdata_in = 4'b0001;
    bus.id_PC_in         = 32'h100 + {25'd0, rn, 2'b00};
    bus.id_NNPC_in       = 32'h108 + {25'd0, rn, 2'b00};
  endtask

  task automatic idle();
    bus.id_valid_in = 1'b0;
  endtask

  localparam logic [11:0] OP_ADD = 12'h001, OP_SUB = 12'h002, OP_SLT = 12'h004,
                          OP_SLTU = 12'h008, OP_AND = 12'h010, OP_NOR = 12'h020,
                          OP_OR = 12'h040, OP_XOR = 12'h080, OP_SLL = 12'h100,
                          OP_SRL = 12'h200, OP_SRA = 12'h400, OP_LUI = 12'h800;

  typedef struct {
    logic [11:0] op;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] exp;
  } alu_vec_t;

  alu_vec_t vecs [14];

  initial begin
    checks = 0;
    errors = 0;
    vecs[0]  = '{OP_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
    vecs[1]  = '{OP_SUB,  32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF};
    vecs[2]  = '{OP_SLT,  32'h8000_0000, 32'h0000_0001, 32'h0000_0001};
    vecs[3]  = '{OP_SLTU, 32'h8000_0000, 32'h0000_0001, 32'h0000_0000};
    vecs[4]  = '{OP_AND,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0};
    vecs[5]  = '{OP_NOR,  32'h0F0F_0000, 32'h0000_00F0, 32'hF0F0_FF0F};
    vecs[6]  = '{OP_OR,   32'h1234_0000, 32'h0000_5678, 32'h1234_5678};
    vecs[7]  = '{OP_XOR,  32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F};
    vecs[8]  = '{OP_SLL,  32'h0000_0004, 32'h0000_0001, 32'h0000_0010};
    vecs[9]  = '{OP_SLL,  32'hFFFF_FFE1, 32'h0000_0003, 32'h0000_0006};
    vecs[10] = '{OP_SRL,  32'h0000_0004, 32'h8000_0000, 32'h0800_0000};
    vecs[11] = '{OP_SRA,  32'h0000_0004, 32'h8000_0000, 32'hF800_0000};
    vecs[12] = '{OP_LUI,  32'h0000_0000, 32'hABCD_1234, 32'h1234_0000};
    vecs[13] = '{12'h000, 32'h1111_1111, 32'h2222_2222, 32'h0000_0000};

    rst_n              = 1'b0;
    bus.mem_allowin_in = 1'b1;
    bus.data_addr_ok   = 1'b0;
    issue(12'h000, '0, '0, 2'b00, 3'b000, '0, 5'd0, 3'b000);
    idle();
    repeat (2) @(negedge clk);
    #1;
    check("rst_valid_out",  {31'd0, bus.exe_valid_out},   32'd0);
    check("rst_allowin",    {31'd0, bus.exe_allowin_out}, 32'd1);
    check("rst_data_req",   {31'd0, bus.data_req},        32'd0);
    check("rst_write_type", {29'd0, bus.exe_write_type},  32'd0);
    check("rst_alures",     bus.exe_alures_out,           32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // ADD wrap with passthrough fields
    @(negedge clk);
    issue(OP_ADD, 32'hFFFF_FFFF, 32'h1, 2'b00, 3'b000, '0, 5'd5, 3'b001);
    @(negedge clk);
    idle();
    #1;
    check("add_res",      bus.exe_alures_out,            32'd0);
    check("add_valid",    {31'd0, bus.exe_valid_out},    32'd1);
    check("add_req",      {31'd0, bus.data_req},         32'd0);
    check("add_wnum",     {27'd0, bus.exe_wnum},         32'd5);
    check("add_wt",       {29'd0, bus.exe_write_type},   32'd1);
    check("add_pc",       bus.exe_PC_out,                32'h114);
    check("add_nnpc",     bus.exe_NNPC_out,              32'h11C);
    check("add_wb",       {28'd0, bus.exe_sel_wbdata_out}, 32'd1);
    @(negedge clk);
    #1;
    check("empty_valid",  {31'd0, bus.exe_valid_out},    32'd0);
    check("empty_wt",     {29'd0, bus.exe_write_type},   32'd0);

    // ALU table, one op at a time
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      issue(vecs[i].op, vecs[i].d1, vecs[i].d2, 2'b00, 3'b000, '0, 5'(i + 1), 3'b001);
      @(negedge clk);
      idle();
      #1;
      check($sformatf("alu_vec%0d", i), bus.exe_alures_out, vecs[i].exp);
    end

    // Back-to-back ops, hazard info tracks each instruction
    @(negedge clk);
    issue(OP_SLT, 32'h8000_0000, 32'h1, 2'b00, 3'b000, '0, 5'd7, 3'b001);
    @(negedge clk);
    issue(OP_SLTU, 32'h8000_0000, 32'h1, 2'b00, 3'b000, '0, 5'd8, 3'b010);
    #1;
    check("b2b0_res",     bus.exe_alures_out,            32'd1);
    check("b2b0_wnum",    {27'd0, bus.exe_wnum},         32'd7);
    check("b2b0_allowin", {31'd0, bus.exe_allowin_out},  32'd1);
    @(negedge clk);
    issue(OP_SRA, 32'h4, 32'h8000_0000, 2'b00, 3'b000, '0, 5'd9, 3'b011);
    #1;
    check("b2b1_res",     bus.exe_alures_out,            32'd0);
    check("b2b1_wnum",    {27'd0, bus.exe_wnum},         32'd8);
    check("b2b1_wt",      {29'd0, bus.exe_write_type},   32'd2);
    @(negedge clk);
    idle();
    #1;
    check("b2b2_res",     bus.exe_alures_out,            32'hF800_0000);
    check("b2b2_wnum",    {27'd0, bus.exe_wnum},         32'd9);
    check("b2b2_wt",      {29'd0, bus.exe_write_type},   32'd3);
    @(negedge clk);
    #1;
    check("b2b_empty_wt", {29'd0, bus.exe_write_type},   32'd0);

    // Store byte, accept delayed; a pending ALU op must wait
    @(negedge clk);
    issue(OP_ADD, 32'h1000_0000, 32'h3, 2'b10, 3'b001, 32'h0000_00AB, 5'd0, 3'b000);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      issue(OP_ADD, 32'h2, 32'h3, 2'b00, 3'b000, '0, 5'd11, 3'b001);
      if (c == 2) bus.data_addr_ok = 1'b1;
      #1;
      check($sformatf("sb_req%0d", c),   {31'd0, bus.data_req},   32'd1);
      check($sformatf("sb_wr%0d", c),    {31'd0, bus.data_wr},    32'd1);
      check($sformatf("sb_addr%0d", c),  bus.data_addr,           32'h1000_0003);
      check($sformatf("sb_wstrb%0d", c), {28'd0, bus.data_wstrb}, 32'h8);
      check($sformatf("sb_wdata%0d", c), bus.data_wdata,          32'hABAB_ABAB);
      check($sformatf("sb_allow%0d", c), {31'd0, bus.exe_allowin_out}, (c == 2) ? 32'd1 : 32'd0);
      check($sformatf("sb_vld%0d", c),   {31'd0, bus.exe_valid_out},   (c == 2) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    bus.data_addr_ok = 1'b0;
    idle();
    #1;
    check("sb_next_req",  {31'd0, bus.data_req},         32'd0);
    check("sb_next_res",  bus.exe_alures_out,            32'd5);
    check("sb_next_wnum", {27'd0, bus.exe_wnum},         32'd11);

    // Half store accepted immediately, word store captured in the same cycle
    @(negedge clk);
    issue(OP_ADD, 32'h2000, 32'h2, 2'b10, 3'b010, 32'h1234_5678, 5'd0, 3'b000);
    @(negedge clk);
    bus.data_addr_ok = 1'b1;
    issue(OP_ADD, 32'h3000, 32'h0, 2'b10, 3'b100, 32'hDEAD_BEEF, 5'd0, 3'b000);
    #1;
    check("sh_wstrb",     {28'd0, bus.data_wstrb},       32'hC);
    check("sh_wdata",     bus.data_wdata,                32'h5678_5678);
    check("sh_allowin",   {31'd0, bus.exe_allowin_out},  32'd1);
    check("sh_valid",     {31'd0, bus.exe_valid_out},    32'd1);
    @(negedge clk);
    idle();
    #1;
    check("sw_req",       {31'd0, bus.data_req},         32'd1);
    check("sw_addr",      bus.data_addr,                 32'h3000);
    check("sw_wstrb",     {28'd0, bus.data_wstrb},       32'hF);
    check("sw_wdata",     bus.data_wdata,                32'hDEAD_BEEF);
    @(negedge clk);
    bus.data_addr_ok = 1'b0;
    #1;
    check("sw_gone_req",  {31'd0, bus.data_req},         32'd0);
    check("sw_gone_vld",  {31'd0, bus.exe_valid_out},    32'd0);

    // Load accepted while MEM stalls
    @(negedge clk);
    bus.mem_allowin_in = 1'b0;
    issue(OP_ADD, 32'h4000, 32'h10, 2'b01, 3'b100, 32'hFFFF_FFFF, 5'd3, 3'b001);
    @(negedge clk);
    bus.data_addr_ok = 1'b1;
    issue(OP_ADD, 32'h1, 32'h1, 2'b00, 3'b000, '0, 5'd12, 3'b001);
    #1;
    check("ld_req",       {31'd0, bus.data_req},         32'd1);
    check("ld_wr",        {31'd0, bus.data_wr},          32'd0);
    check("ld_wstrb",     {28'd0, bus.data_wstrb},       32'd0);
    check("ld_wdata",     bus.data_wdata,                32'd0);
    check("ld_valid",     {31'd0, bus.exe_valid_out},    32'd1);
    check("ld_allowin",   {31'd0, bus.exe_allowin_out},  32'd0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      bus.data_addr_ok = 1'b0;
      #1;
      check($sformatf("ld_stall_req%0d", c),   {31'd0, bus.data_req},        32'd0);
      check($sformatf("ld_stall_vld%0d", c),   {31'd0, bus.exe_valid_out},   32'd1);
      check($sformatf("ld_stall_allow%0d", c), {31'd0, bus.exe_allowin_out}, 32'd0);
      check($sformatf("ld_stall_addr%0d", c),  bus.data_addr,                32'h4010);
    end
    @(negedge clk);
    bus.mem_allowin_in = 1'b1;
    #1;
    check("ld_release_allow", {31'd0, bus.exe_allowin_out}, 32'd1);
    check("ld_release_req",   {31'd0, bus.data_req},        32'd0);
    @(negedge clk);
    idle();
    #1;
    check("ld_next_res",  bus.exe_alures_out,            32'd2);
    check("ld_next_wnum", {27'd0, bus.exe_wnum},         32'd12);

    // Reset in the middle of a pending request
    @(negedge clk);
    issue(OP_ADD, 32'h5000, 32'h0, 2'b10, 3'b100, 32'h1, 5'd0, 3'b000);
    @(negedge clk);
    idle();
    #1;
    check("rr_req_before", {31'd0, bus.data_req},        32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rr_req_async",  {31'd0, bus.data_req},        32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      check($sformatf("rr_req_after%0d", c),  {31'd0, bus.data_req},        32'd0);
      check($sformatf("rr_allow_after%0d", c), {31'd0, bus.exe_allowin_out}, 32'd1);
      check($sformatf("rr_vld_after%0d", c),   {31'd0, bus.exe_valid_out},   32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
